// File: rtl/ulpb_pkg.sv
// Shared definitions for the ULPB node: state encodings, acknowledge pattern,
// default idle length and the width helper used to size counters.
package ulpb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_REQUEST    = 4'd1,
    ST_ARBITRATE  = 4'd2,
    ST_SEND_DRIVE = 4'd3,
    ST_SEND_LATCH = 4'd4,
    ST_INTERJECT  = 4'd5,
    ST_WAIT_RESET = 4'd6,
    ST_DONE       = 4'd7,
    ST_BACKOFF    = 4'd8
  } ulpb_state_e;

  // Receiver acknowledge as seen on the first two rises after an interjection.
  localparam logic [1:0] ACK_PATTERN = 2'b10;

  localparam int IDLE_CYCLES_DEFAULT = 16;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int ulpb_clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ulpb_node_tx_bus_clk_edge.sv
// Registers BUS_CLK once and flags its rising and falling edges for the cycle
// in which they are first seen.
module ulpb_bus_clk_edge (
  input  logic CLK,
  input  logic RESET,
  input  logic BUS_CLK,
  output logic rise,
  output logic fall
);

  logic bclk_q;

  // The bus idles high, so start high to avoid a spurious rise after reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) bclk_q <= 1'b1;
    else        bclk_q <= BUS_CLK;
  end

  assign rise = BUS_CLK & ~bclk_q;
  assign fall = ~BUS_CLK & bclk_q;

endmodule

// File: rtl/ulpb_node_tx.sv
// ULPB ring-bus transmit node: arbitrates, shifts address+data MSB first,
// interjects to end the message. Optional ACK sampling: ULPB_NODE_TX_ACK_EN.
module ulpb_node_tx
  import ulpb_pkg::*;
#(
  parameter int ADDR_WIDTH       = 8,
  parameter int DATA_WIDTH       = 32,
  parameter int INTERJECT_CYCLES = 4,
  parameter int IDLE_CYCLES      = IDLE_CYCLES_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  BUS_CLK,
  input  logic                  DIN,
  output logic                  DOUT,
  input  logic                  TX_REQ,
  input  logic [ADDR_WIDTH-1:0] TX_ADDR,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_DONE,
  output logic                  TX_FAIL,
`ifdef ULPB_NODE_TX_ACK_EN
  output logic                  TX_NAK,
`endif
  output logic [3:0]            test_pt
);

  localparam int MSG_W  = ADDR_WIDTH + DATA_WIDTH;
  localparam int BIT_W  = ulpb_clog2(MSG_W);
  localparam int IDLE_W = ulpb_clog2(IDLE_CYCLES + 1);
  localparam int IJ_W   = ulpb_clog2(INTERJECT_CYCLES);

  ulpb_state_e        state_reg, state_next;
  logic               drive_en_reg, drive_en_next;
  logic               drive_val_reg, drive_val_next;
  logic [MSG_W-1:0]   shift_reg, shift_next;
  logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [IJ_W-1:0]    ij_cnt_reg, ij_cnt_next;
  logic [IDLE_W-1:0]  idle_cnt_reg;
  logic               mism_reg;
  logic               fail_reg, fail_next;
  logic               rise, fall, bus_idle, mismatch;
`ifdef ULPB_NODE_TX_ACK_EN
  logic [1:0]         ack_cnt_reg, ack_cnt_next;
  logic [1:0]         ack_bits_reg, ack_bits_next;
  logic               nak_reg, nak_next;
`endif

  ulpb_bus_clk_edge u_edge (
    .CLK     (CLK),
    .RESET   (RESET),
    .BUS_CLK (BUS_CLK),
    .rise    (rise),
    .fall    (fall)
  );

  assign DOUT     = drive_en_reg ? drive_val_reg : DIN;
  assign test_pt  = state_reg;
  assign bus_idle = (idle_cnt_reg == IDLE_W'(IDLE_CYCLES));

  // Upstream disagreeing with our bit while the bus clock is high means a
  // foreign reset is in progress; two consecutive cycles confirm it.
  assign mismatch = ((state_reg == ST_SEND_DRIVE) || (state_reg == ST_SEND_LATCH)) &&
                    BUS_CLK && (DIN != drive_val_reg);

`ifdef ULPB_NODE_TX_ACK_EN
  assign TX_DONE = (state_reg == ST_DONE) && !nak_reg;
  assign TX_NAK  = (state_reg == ST_DONE) && nak_reg;
  assign TX_FAIL = fail_reg || TX_NAK;
`else
  assign TX_DONE = (state_reg == ST_DONE);
  assign TX_FAIL = fail_reg;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      idle_cnt_reg <= '0;
    end else if (BUS_CLK && DIN) begin
      if (!bus_idle) idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
    end else begin
      idle_cnt_reg <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg     <= ST_IDLE;
      drive_en_reg  <= 1'b0;
      drive_val_reg <= 1'b1;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      ij_cnt_reg    <= '0;
      mism_reg      <= 1'b0;
      fail_reg      <= 1'b0;
`ifdef ULPB_NODE_TX_ACK_EN
      ack_cnt_reg   <= '0;
      ack_bits_reg  <= '0;
      nak_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      drive_en_reg  <= drive_en_next;
      drive_val_reg <= drive_val_next;
      shift_reg     <= shift_next;
      bit_cnt_reg   <= bit_cnt_next;
      ij_cnt_reg    <= ij_cnt_next;
      mism_reg      <= mismatch;
      fail_reg      <= fail_next;
`ifdef ULPB_NODE_TX_ACK_EN
      ack_cnt_reg   <= ack_cnt_next;
      ack_bits_reg  <= ack_bits_next;
      nak_reg       <= nak_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    drive_en_next  = drive_en_reg;
    drive_val_next = drive_val_reg;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt_reg;
    ij_cnt_next    = ij_cnt_reg;
    fail_next      = 1'b0;
`ifdef ULPB_NODE_TX_ACK_EN
    ack_cnt_next   = ack_cnt_reg;
    ack_bits_next  = ack_bits_reg;
    nak_next       = nak_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (TX_REQ && bus_idle) begin
          shift_next     = {TX_ADDR, TX_DATA};
          bit_cnt_next   = BIT_W'(MSG_W - 1);
          drive_en_next  = 1'b1;
          drive_val_next = 1'b0;
          state_next     = ST_REQUEST;
        end
      end
      ST_REQUEST: if (fall) state_next = ST_ARBITRATE;
      ST_ARBITRATE: begin
        if (rise) begin
          if (DIN) begin
            state_next = ST_SEND_DRIVE;
          end else begin
            drive_en_next = 1'b0;
            state_next    = ST_BACKOFF;
          end
        end
      end
      ST_SEND_DRIVE: begin
        if (fall) begin
          drive_val_next = shift_reg[MSG_W-1];
          shift_next     = {shift_reg[MSG_W-2:0], 1'b0};
          state_next     = ST_SEND_LATCH;
        end
      end
      ST_SEND_LATCH: begin
        if (rise) begin
          if (bit_cnt_reg == '0) begin
            ij_cnt_next = IJ_W'(INTERJECT_CYCLES - 1);
            state_next  = ST_INTERJECT;
          end else begin
            bit_cnt_next = bit_cnt_reg - BIT_W'(1);
            state_next   = ST_SEND_DRIVE;
          end
        end
      end
      ST_INTERJECT: begin
        drive_val_next = ~drive_val_reg;
        if (ij_cnt_reg == '0) begin
          drive_en_next = 1'b0;
          state_next    = ST_WAIT_RESET;
`ifdef ULPB_NODE_TX_ACK_EN
          ack_cnt_next  = '0;
          ack_bits_next = '0;
`endif
        end else begin
          ij_cnt_next = ij_cnt_reg - IJ_W'(1);
        end
      end
      ST_WAIT_RESET: begin
`ifdef ULPB_NODE_TX_ACK_EN
        if (rise && (ack_cnt_reg != 2'd2)) begin
          ack_bits_next = {ack_bits_reg[0], DIN};
          ack_cnt_next  = ack_cnt_reg + 2'd1;
        end
        // A rise can never coincide with bus_idle, so the sampled bits are final here.
        if (bus_idle) begin
          nak_next   = (ack_cnt_reg != 2'd2) || (ack_bits_reg != ACK_PATTERN);
          state_next = ST_DONE;
        end
`else
        if (bus_idle) state_next = ST_DONE;
`endif
      end
      ST_DONE:    state_next = ST_IDLE;
      ST_BACKOFF: if (bus_idle) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase

    if (mismatch && mism_reg) begin
      drive_en_next = 1'b0;
      fail_next     = 1'b1;
      state_next    = ST_BACKOFF;
    end
  end

endmodule

// File: tb/tb_ulpb_node_tx.sv
// Directed bench for ulpb_node_tx: a bus-controller model clocks messages out,
// a scoreboard queue holds the expected bit stream.
module tb_ulpb_node_tx;
  import ulpb_pkg::*;

  logic        clk, rst_n, bus_clk, din, dout, tx_req, tx_done, tx_fail;
  logic [7:0]  tx_addr;
  logic [31:0] tx_data;
  logic [3:0]  test_pt;
`ifdef ULPB_NODE_TX_ACK_EN
  logic        tx_nak;
`endif
  bit          loop_en;
  logic        exp_q[$];
  int          checks, errors, done_cnt, fail_cnt, exp_done, exp_fail, n;

  ulpb_node_tx dut (
    .CLK     (clk),
    .RESET   (rst_n),
    .BUS_CLK (bus_clk),
    .DIN     (din),
    .DOUT    (dout),
    .TX_REQ  (tx_req),
    .TX_ADDR (tx_addr),
    .TX_DATA (tx_data),
    .TX_DONE (tx_done),
    .TX_FAIL (tx_fail),
`ifdef ULPB_NODE_TX_ACK_EN
    .TX_NAK  (tx_nak),
`endif
    .test_pt (test_pt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_fail) fail_cnt <= fail_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ring loopback: upstream echoes what we drive once the message is under way.
  task automatic tick();
    @(posedge clk);
    #1;
    if (loop_en) din = dout;
  endtask

  task automatic bus_low(input int cyc);
    bus_clk = 1'b0;
    repeat (cyc) tick();
  endtask

  task automatic bus_high(input int cyc);
    bus_clk = 1'b1;
    repeat (cyc) tick();
  endtask

  task automatic idle_bus(input int cyc);
    loop_en = 1'b0;
    din     = 1'b1;
    bus_high(cyc);
  endtask

  task automatic wait_state(input logic [3:0] st, input int budget, output int cnt);
    cnt = 0;
    while (test_pt !== st && cnt < budget) begin
      tick();
      cnt++;
    end
    check("wait_state", 64'(test_pt), 64'(st));
  endtask

  task automatic accept(input logic [7:0] a, input logic [31:0] d);
    tx_addr = a;
    tx_data = d;
    tx_req  = 1'b1;
    tick();
  endtask

  // mode: 0 normal, 1 lose arbitration, 2 foreign reset at bit 10, 3 RESET at bit 5
  task automatic run_msg(input logic [7:0] a, input logic [31:0] d, input int mode,
                         input logic [1:0] ack, input bit exp_ok);
    logic [39:0] msg;
    logic        prev, exp_b;
    int          cnt;
    msg = {a, d};
    $display("tx addr=%02h data=%08h mode=%0d ack=%b", a, d, mode, ack);
    check("request_state", 64'(test_pt), 64'(ST_REQUEST));
    check("request_drive", 64'(dout), 64'd0);
    bus_low(4);
    check("arbitrate_state", 64'(test_pt), 64'(ST_ARBITRATE));
    if (mode == 1) begin
      din = 1'b0;
      bus_high(1);
      check("lose_state", 64'(test_pt), 64'(ST_BACKOFF));
      din = 1'b1;
      #1;
      check("lose_forward", 64'(dout), 64'd1);
      check("lose_no_pulse", 64'({tx_done, tx_fail}), 64'd0);
      return;
    end
    din = 1'b1;
    bus_high(1);
    check("win_state", 64'(test_pt), 64'(ST_SEND_DRIVE));
    loop_en = 1'b1;
    din     = dout;
    bus_high(3);
    for (int i = 39; i >= 0; i--) exp_q.push_back(msg[i]);
    for (int b = 0; b < 40; b++) begin
      bus_low(2);
      if (mode == 3 && b == 5) begin
        din = ~din;
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_forward", 64'(dout), 64'(din));
        check("areset_state", 64'(test_pt), 64'(ST_IDLE));
        check("areset_pulses", 64'({tx_done, tx_fail}), 64'd0);
        tx_req  = 1'b0;
        loop_en = 1'b0;
        din     = 1'b1;
        bus_clk = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        return;
      end
      bus_low(2);
      if (mode == 2 && b == 10) begin
        loop_en = 1'b0;
        din     = ~dout;
        bus_high(2);
        check("freset_pulse", 64'(tx_fail), 64'd1);
        check("freset_state", 64'(test_pt), 64'(ST_BACKOFF));
        tx_req = 1'b0;
        din = 1'b0;
        #1;
        check("freset_fwd0", 64'(dout), 64'd0);
        din = 1'b1;
        #1;
        check("freset_fwd1", 64'(dout), 64'd1);
        tick();
        check("freset_pulse_width", 64'(tx_fail), 64'd0);
        wait_state(ST_IDLE, 40, cnt);
        exp_fail++;
        exp_q.delete();
        return;
      end
      bus_high(1);
      check("bit", 64'(dout), 64'(exp_q.pop_front()));
      if (b < 39) bus_high(3);
    end
    check("interject_state", 64'(test_pt), 64'(ST_INTERJECT));
    prev = dout;
    for (int k = 1; k < 4; k++) begin
      tick();
      check("interject_state", 64'(test_pt), 64'(ST_INTERJECT));
      exp_b = ~prev;
      check("interject_toggle", 64'(dout), 64'(exp_b));
      prev = dout;
    end
    tick();
    check("wait_reset_state", 64'(test_pt), 64'(ST_WAIT_RESET));
    loop_en = 1'b0;
    for (int k = 1; k >= 0; k--) begin
      din = ack[k];
      bus_low(4);
      bus_high(4);
    end
    din = 1'b1;
    cnt = 0;
    while (!(tx_done || tx_fail) && cnt < 60) begin
      tick();
      cnt++;
    end
    check("done_pulse", 64'(tx_done), 64'(exp_ok));
    check("fail_pulse", 64'(tx_fail), 64'(!exp_ok));
`ifdef ULPB_NODE_TX_ACK_EN
    check("nak_pulse", 64'(tx_nak), 64'(!exp_ok));
`endif
    tx_req = 1'b0;
    if (exp_ok) exp_done++;
    else        exp_fail++;
    tick();
    check("after_done_state", 64'(test_pt), 64'(ST_IDLE));
    check("after_done_pulse", 64'({tx_done, tx_fail}), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    checks = 0; errors = 0; done_cnt = 0; fail_cnt = 0; exp_done = 0; exp_fail = 0;
    rst_n = 1'b0; bus_clk = 1'b1; din = 1'b0; tx_req = 1'b0;
    tx_addr = '0; tx_data = '0; loop_en = 1'b0;
    #12;
    check("reset_state", 64'(test_pt), 64'(ST_IDLE));
    check("reset_forward0", 64'(dout), 64'd0);
    din = 1'b1;
    #1;
    check("reset_forward1", 64'(dout), 64'd1);
    check("reset_pulses", 64'({tx_done, tx_fail}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_bus(20);
    check("idle_state", 64'(test_pt), 64'(ST_IDLE));

    accept(8'hA5, 32'h0000_0001);
    run_msg(8'hA5, 32'h0000_0001, 0, 2'b10, 1'b1);

    idle_bus(2);
    accept(8'h5A, 32'h1234_5678);
    run_msg(8'h5A, 32'h1234_5678, 1, 2'b10, 1'b1);
    wait_state(ST_REQUEST, 60, n);
    run_msg(8'h5A, 32'h1234_5678, 0, 2'b10, 1'b1);

    idle_bus(2);
    accept(8'hC3, 32'hF0F0_0F0F);
    run_msg(8'hC3, 32'hF0F0_0F0F, 2, 2'b10, 1'b1);

    idle_bus(2);
    accept(8'h96, 32'h8000_0003);
    run_msg(8'h96, 32'h8000_0003, 3, 2'b10, 1'b1);
    idle_bus(20);
    check("post_areset_state", 64'(test_pt), 64'(ST_IDLE));

    bus_low(1);
    tx_addr = 8'h3C;
    tx_data = 32'hDEAD_BEEF;
    tx_req  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("busy_no_drive", 64'(dout), 64'd1);
      check("busy_state", 64'(test_pt), 64'(ST_IDLE));
      bus_high(4);
      check("busy_state", 64'(test_pt), 64'(ST_IDLE));
      bus_low(4);
    end
    bus_clk = 1'b1;
    wait_state(ST_REQUEST, 40, n);
    check("idle_wait_cycles", 64'(n), 64'd17);
    run_msg(8'h3C, 32'hDEAD_BEEF, 0, 2'b10, 1'b1);

`ifdef ULPB_NODE_TX_ACK_EN
    idle_bus(2);
    accept(8'h81, 32'h0000_00FF);
    run_msg(8'h81, 32'h0000_00FF, 0, 2'b10, 1'b1);
    idle_bus(2);
    accept(8'h42, 32'h0F0F_F0F0);
    run_msg(8'h42, 32'h0F0F_F0F0, 0, 2'b11, 1'b0);
`endif

    idle_bus(3);
    check("done_count", 64'(done_cnt), 64'(exp_done));
    check("fail_count", 64'(fail_cnt), 64'(exp_fail));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
